// File: rtl/scan_decoder_pkg.sv
// Shared encodings for the scan decoder: the mode input values and the
// controller state type, plus the dwell counter width.
package scan_decoder_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

   // Wide enough for the largest legal DWELL of 255.
   localparam int DWELL_W = 8;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Purely combinational binary to one-hot decoder; output bit `code` is set.
module onehot_dec #(
   parameter int IN_W = 4,
   localparam int OUT_W = 2 ** IN_W
) (
   input  logic [IN_W-1:0]  code,
   output logic [OUT_W-1:0] y
);

   assign y = OUT_W'(1) << code;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder that either decodes offered codes (direct mode)
// or sweeps every index with a per-index dwell time (scan mode).
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int DWELL = 4,
   localparam int OUT_W = 2 ** IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] y,
   output logic [IN_W-1:0]  idx
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

   state_e             st, st_d;
   logic [IN_W-1:0]    idx_q, idx_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               ov_q, ov_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [OUT_W-1:0]   dec_y;
   logic               out_xfer;

   // Handshake: a beat moves when valid and ready are both high on a rising
   // edge; in_ready never depends on in_valid, out_valid never on out_ready.
   always_comb begin
      st_d     = st;
      idx_d    = idx_q;
      dwell_d  = dwell_q;
      ov_d     = ov_q;
      in_ready = 1'b0;
      out_xfer = ov_q && out_ready;
      case (st)
         ST_DIRECT: begin
            if (mode == MODE_SCAN) begin
               // Codes are refused while a scan request is pending so none is dropped.
               if (!ov_q || out_xfer) begin
                  st_d    = ST_SCAN;
                  idx_d   = '0;
                  dwell_d = '0;
                  ov_d    = 1'b1;
               end
            end else begin
               in_ready = rst_n && (!ov_q || out_ready);
               if (in_valid && in_ready) begin
                  idx_d = code;
                  ov_d  = 1'b1;
               end else if (out_xfer) begin
                  ov_d = 1'b0;
               end
            end
         end
         ST_SCAN: begin
            if (dwell_q != DWELL_LAST) begin
               dwell_d = dwell_q + 1'b1;
            end else if (out_ready) begin
               dwell_d = '0;
               if (mode == MODE_DIRECT) begin
                  st_d = ST_DIRECT;
                  ov_d = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: st_d = ST_DIRECT;
      endcase
   end

   onehot_dec #(.IN_W(IN_W)) u_dec (
      .code (idx_d),
      .y    (dec_y)
   );

   // Blank on en=0 and whenever no beat is held, so y is zero or one-hot.
   assign y_d = (en && ov_d) ? dec_y : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_DIRECT;
         idx_q   <= '0;
         dwell_q <= '0;
         ov_q    <= 1'b0;
         y_q     <= '0;
      end else begin
         st      <= st_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         ov_q    <= ov_d;
         y_q     <= y_d;
      end
   end

   assign out_valid = ov_q;
   assign y         = y_q;
   assign idx       = idx_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder (IN_W=4, DWELL=4) with
// hand-computed expected values.
module tb_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic        en;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  code;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic [3:0]  idx;

   int checks = 0;
   int errors = 0;

   scan_decoder #(.IN_W(4), .DWELL(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .code      (code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .idx       (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      en        = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      code      = 4'd0;
      #2;
      check("rst_y", 32'(y), 32'h0);
      check("rst_idx", 32'(idx), 32'h0);
      check("rst_ov", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      step();
      #2 rst_n = 1'b1;
      step();
      check("idle_in_ready", 32'(in_ready), 32'h1);
      check("idle_ov", 32'(out_valid), 32'h0);

      // Direct decode of 13
      code = 4'b1101; in_valid = 1'b1; out_ready = 1'b1;
      step();
      check("dir_y", 32'(y), 32'h2000);
      check("dir_idx", 32'(idx), 32'd13);
      check("dir_ov", 32'(out_valid), 32'h1);

      // Backpressure: new code must wait
      out_ready = 1'b0; code = 4'b0010;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_y_hold", 32'(y), 32'h2000);
      check("bp_idx_hold", 32'(idx), 32'd13);
      check("bp_ov_hold", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_up", 32'(in_ready), 32'h1);
      step();
      check("bp_reload_y", 32'(y), 32'h0004);
      check("bp_reload_idx", 32'(idx), 32'd2);
      check("bp_reload_ov", 32'(out_valid), 32'h1);
      in_valid = 1'b0;
      step();
      check("drain_ov", 32'(out_valid), 32'h0);
      check("drain_y", 32'(y), 32'h0);

      // Blanking
      en = 1'b0; code = 4'b0110; in_valid = 1'b1;
      step();
      check("blank_y", 32'(y), 32'h0);
      check("blank_idx", 32'(idx), 32'd6);
      check("blank_ov", 32'(out_valid), 32'h1);
      in_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
      step();
      check("unblank_y", 32'(y), 32'h0040);
      check("unblank_ov", 32'(out_valid), 32'h1);

      // Scan sweep: held beat drains on the same edge that enters scan
      mode = 1'b1; out_ready = 1'b1;
      step();
      check("scan_in_ready", 32'(in_ready), 32'h0);
      check("scan_ov", 32'(out_valid), 32'h1);
      for (int c = 0; c <= 64; c++) begin
         check($sformatf("scan_y_c%0d", c), 32'(y), 32'h1 << ((c / 4) % 16));
         if (c < 64) step();
      end

      // Reach idx 5, dwell 3 (23 cycles into the sweep) then stall
      for (int c = 0; c < 23; c++) step();
      check("stall_pre_idx", 32'(idx), 32'd5);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("stall_idx_%0d", c), 32'(idx), 32'd5);
         check($sformatf("stall_ov_%0d", c), 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      step();
      check("stall_release_idx", 32'(idx), 32'd6);
      check("stall_release_y", 32'(y), 32'h0040);

      // Advance to idx 9 and reset asynchronously mid-cycle
      for (int c = 0; c < 12; c++) step();
      check("pre_rst_idx", 32'(idx), 32'd9);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_y", 32'(y), 32'h0);
      check("async_rst_idx", 32'(idx), 32'h0);
      check("async_rst_ov", 32'(out_valid), 32'h0);
      check("async_rst_in_ready", 32'(in_ready), 32'h0);
      mode = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", 32'(in_ready), 32'h1);
      check("post_rst_ov", 32'(out_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
